// File: rtl/demux_1x3_reg_pkg.sv
// Shared select encodings for the routing blocks (mux_4x1, demux_1x3_reg)
// and the demux holding-slot state type.
package demux_1x3_reg_pkg;

    typedef enum logic [1:0] {
        MUX_SEL_A = 2'b00,
        MUX_SEL_B = 2'b01,
        MUX_SEL_C = 2'b10,
        MUX_SEL_D = 2'b11
    } mux4_sel_e;

    typedef enum logic [1:0] {
        SEL_P1  = 2'b00,
        SEL_P2  = 2'b01,
        SEL_P3  = 2'b10,
        SEL_BAD = 2'b11
    } demux_sel_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    localparam int NUM_PORTS = 3;

endpackage

// File: rtl/demux_1x3_reg_slot.sv
// One-entry holding register with valid/ready; reloads in the same cycle it
// drains so a port can sustain one word per clock.
module demux_slot
    import demux_1x3_reg_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_rdy,
    output logic [WIDTH-1:0] o_val,
    output logic             o_vld,
    output logic             o_ready
);

    slot_state_e      r_state;
    logic [WIDTH-1:0] r_val;

    // i_load is only raised by the parent while o_ready is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
            r_val   <= '0;
        end else begin
            case (r_state)
                SLOT_EMPTY: begin
                    if (i_load) begin
                        r_state <= SLOT_FULL;
                        r_val   <= i_data;
                    end
                end
                SLOT_FULL: begin
                    if (i_load) begin
                        r_val <= i_data;
                    end else if (i_rdy) begin
                        r_state <= SLOT_EMPTY;
                    end
                end
                default: r_state <= SLOT_EMPTY;
            endcase
        end
    end

    assign o_val   = r_val;
    assign o_vld   = (r_state == SLOT_FULL);
    assign o_ready = (r_state == SLOT_EMPTY) || i_rdy;

endmodule

// File: rtl/demux_1x3_reg.sv
// Registered 1-to-3 demultiplexer: routes each accepted word to one of three
// holding slots; illegal-select words are dropped, flagged and counted.
module demux_1x3_reg
    import demux_1x3_reg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [WIDTH-1:0] val1,
    output logic [WIDTH-1:0] val2,
    output logic [WIDTH-1:0] val3,
    output logic             vld1,
    output logic             vld2,
    output logic             vld3,
    input  logic             rdy1,
    input  logic             rdy2,
    input  logic             rdy3,
    output logic             sel_err,
    output logic [CNTW-1:0]  drop_cnt
);

    logic [NUM_PORTS-1:0]            w_load;
    logic [NUM_PORTS-1:0]            w_port_rdy;
    logic [NUM_PORTS-1:0]            w_slot_ready;
    logic [NUM_PORTS-1:0]            w_vld;
    logic [NUM_PORTS-1:0][WIDTH-1:0] w_val;
    logic                            w_take;
    logic                            w_bad;
    logic                            r_sel_err;
    logic [CNTW-1:0]                 r_drop_cnt;

    assign w_port_rdy = {rdy3, rdy2, rdy1};

    // Ready looks only at the selected slot so a stalled port never blocks others.
    always_comb begin
        in_ready = 1'b1;
        case (in_sel)
            SEL_P1:  in_ready = w_slot_ready[0];
            SEL_P2:  in_ready = w_slot_ready[1];
            SEL_P3:  in_ready = w_slot_ready[2];
            default: in_ready = 1'b1;
        endcase
    end

    assign w_take = in_valid && in_ready;
    assign w_bad  = w_take && (in_sel == SEL_BAD);

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slot
        assign w_load[g] = w_take && (in_sel == 2'(g));

        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load[g]),
            .i_data  (in_data),
            .i_rdy   (w_port_rdy[g]),
            .o_val   (w_val[g]),
            .o_vld   (w_vld[g]),
            .o_ready (w_slot_ready[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_sel_err <= w_bad;
            if (w_bad && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNTW'(1);
            end
        end
    end

    assign val1     = w_val[0];
    assign val2     = w_val[1];
    assign val3     = w_val[2];
    assign vld1     = w_vld[0];
    assign vld2     = w_vld[1];
    assign vld3     = w_vld[2];
    assign sel_err  = r_sel_err;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_demux_1x3_reg.sv
// Scenario bench for demux_1x3_reg: expected words queue per port when driven
// and are popped when the port hands a word off.
module tb_demux_1x3_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [1:0]  in_sel = '0;
    logic [15:0] val1, val2, val3;
    logic        vld1, vld2, vld3;
    logic        rdy1 = 1'b1, rdy2 = 1'b1, rdy3 = 1'b1;
    logic        sel_err;
    logic [7:0]  drop_cnt;

    int vec_cnt = 0;
    int miss_cnt = 0;
    logic [15:0] q1[$], q2[$], q3[$];
    logic [15:0] exp_w;

    demux_1x3_reg #(.WIDTH(16), .CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .val1(val1), .val2(val2), .val3(val3),
        .vld1(vld1), .vld2(vld2), .vld3(vld3),
        .rdy1(rdy1), .rdy2(rdy2), .rdy3(rdy3),
        .sel_err(sel_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        vec_cnt++; if ({vld1, vld2, vld3} !== 3'b000) begin miss_cnt++; $display("FAIL reset_vld: got %b want 000", {vld1, vld2, vld3}); end
        vec_cnt++; if ({val1, val2, val3} !== 48'h0) begin miss_cnt++; $display("FAIL reset_val: got %h want 0", {val1, val2, val3}); end
        vec_cnt++; if (drop_cnt !== 8'h00) begin miss_cnt++; $display("FAIL reset_drop: got %h want 00", drop_cnt); end
        vec_cnt++; if (sel_err !== 1'b0) begin miss_cnt++; $display("FAIL reset_selerr: got %b want 0", sel_err); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        rdy1 = 1; rdy2 = 1; rdy3 = 1;
        in_valid = 1; in_data = 16'h1234; in_sel = 2'b00;
        #1;
        vec_cnt++; if (in_ready !== 1'b1) begin miss_cnt++; $display("FAIL basic_ready: got %b want 1", in_ready); end
        q1.push_back(16'h1234);
        tick();
        in_valid = 0;
        #1;
        vec_cnt++; if ({vld1, vld2, vld3} !== 3'b100) begin miss_cnt++; $display("FAIL basic_vld: got %b want 100", {vld1, vld2, vld3}); end
        exp_w = q1.pop_front();
        vec_cnt++; if (val1 !== exp_w) begin miss_cnt++; $display("FAIL basic_val1: got %h want %h", val1, exp_w); end
        tick();
        vec_cnt++; if (vld1 !== 1'b0) begin miss_cnt++; $display("FAIL basic_drain: got %b want 0", vld1); end
        vec_cnt++; if (val1 !== 16'h1234) begin miss_cnt++; $display("FAIL basic_hold: got %h want 1234", val1); end
    endtask

    task automatic test_backpressure();
        rdy2 = 0;
        in_valid = 1; in_data = 16'hAAAA; in_sel = 2'b01;
        #1;
        vec_cnt++; if (in_ready !== 1'b1) begin miss_cnt++; $display("FAIL bp_first_ready: got %b want 1", in_ready); end
        q2.push_back(16'hAAAA);
        tick();
        in_data = 16'hBBBB;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) in_data = 16'h1111;
            #1;
            vec_cnt++; if (in_ready !== 1'b0) begin miss_cnt++; $display("FAIL bp_stall_ready[%0d]: got %b want 0", i, in_ready); end
            vec_cnt++; if (vld2 !== 1'b1 || val2 !== q2[0]) begin miss_cnt++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h", i, vld2, val2, q2[0]); end
            tick();
        end
        in_data = 16'hBBBB;
        rdy2 = 1;
        #1;
        vec_cnt++; if (in_ready !== 1'b1) begin miss_cnt++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        exp_w = q2.pop_front();
        vec_cnt++; if (val2 !== exp_w) begin miss_cnt++; $display("FAIL bp_first_word: got %h want %h", val2, exp_w); end
        q2.push_back(16'hBBBB);
        tick();
        in_valid = 0;
        #1;
        exp_w = q2.pop_front();
        vec_cnt++; if (vld2 !== 1'b1 || val2 !== exp_w) begin miss_cnt++; $display("FAIL bp_second_word: got %b/%h want 1/%h", vld2, val2, exp_w); end
        tick();
        vec_cnt++; if (vld2 !== 1'b0) begin miss_cnt++; $display("FAIL bp_drain: got %b want 0", vld2); end
    endtask

    task automatic test_independent();
        rdy1 = 0;
        in_valid = 1; in_data = 16'h7777; in_sel = 2'b00;
        q1.push_back(16'h7777);
        tick();
        in_data = 16'h5555; in_sel = 2'b10;
        #1;
        vec_cnt++; if (in_ready !== 1'b1) begin miss_cnt++; $display("FAIL indep_ready: got %b want 1", in_ready); end
        q3.push_back(16'h5555);
        tick();
        in_valid = 0; in_sel = 2'b00;
        #1;
        vec_cnt++; if (in_ready !== 1'b0) begin miss_cnt++; $display("FAIL indep_p1_blocked: got %b want 0", in_ready); end
        exp_w = q3.pop_front();
        vec_cnt++; if (vld3 !== 1'b1 || val3 !== exp_w) begin miss_cnt++; $display("FAIL indep_p3: got %b/%h want 1/%h", vld3, val3, exp_w); end
        vec_cnt++; if (vld1 !== 1'b1 || val1 !== q1[0]) begin miss_cnt++; $display("FAIL indep_p1_hold: got %b/%h want 1/%h", vld1, val1, q1[0]); end
        rdy1 = 1;
        #1;
        exp_w = q1.pop_front();
        vec_cnt++; if (val1 !== exp_w) begin miss_cnt++; $display("FAIL indep_p1_word: got %h want %h", val1, exp_w); end
        tick();
        vec_cnt++; if ({vld1, vld2, vld3} !== 3'b000) begin miss_cnt++; $display("FAIL indep_drain: got %b want 000", {vld1, vld2, vld3}); end
    endtask

    task automatic test_drops();
        int pulses = 0;
        logic [7:0] exp_cnt;
        in_valid = 1; in_sel = 2'b11;
        for (int i = 1; i <= 300; i++) begin
            in_data = 16'($urandom);
            #1;
            vec_cnt++; if (in_ready !== 1'b1) begin miss_cnt++; $display("FAIL drop_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            if (sel_err === 1'b1) pulses++;
            exp_cnt = (i > 255) ? 8'hFF : 8'(i);
            vec_cnt++; if (drop_cnt !== exp_cnt) begin miss_cnt++; $display("FAIL drop_cnt[%0d]: got %h want %h", i, drop_cnt, exp_cnt); end
            vec_cnt++; if ({vld1, vld2, vld3} !== 3'b000) begin miss_cnt++; $display("FAIL drop_vld[%0d]: got %b want 000", i, {vld1, vld2, vld3}); end
        end
        in_valid = 0;
        tick();
        vec_cnt++; if (sel_err !== 1'b0) begin miss_cnt++; $display("FAIL drop_err_clear: got %b want 0", sel_err); end
        vec_cnt++; if (pulses != 300) begin miss_cnt++; $display("FAIL drop_pulses: got %0d want 300", pulses); end
        vec_cnt++; if (drop_cnt !== 8'hFF) begin miss_cnt++; $display("FAIL drop_sat: got %h want ff", drop_cnt); end
    endtask

    task automatic test_stream();
        rdy1 = 1;
        in_sel = 2'b00; in_valid = 1;
        for (int i = 0; i < 20; i++) begin
            in_data = 16'($urandom);
            #1;
            vec_cnt++; if (in_ready !== 1'b1) begin miss_cnt++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready); end
            if (i > 0) begin
                exp_w = q1.pop_front();
                vec_cnt++; if (vld1 !== 1'b1 || val1 !== exp_w) begin miss_cnt++; $display("FAIL stream_word[%0d]: got %b/%h want 1/%h", i, vld1, val1, exp_w); end
            end
            q1.push_back(in_data);
            tick();
        end
        in_valid = 0;
        #1;
        exp_w = q1.pop_front();
        vec_cnt++; if (vld1 !== 1'b1 || val1 !== exp_w) begin miss_cnt++; $display("FAIL stream_last: got %b/%h want 1/%h", vld1, val1, exp_w); end
        tick();
        vec_cnt++; if (vld1 !== 1'b0) begin miss_cnt++; $display("FAIL stream_drain: got %b want 0", vld1); end
    endtask

    task automatic test_reset_mid();
        rdy1 = 0; rdy2 = 0; rdy3 = 0;
        in_valid = 1;
        in_data = 16'hC001; in_sel = 2'b00; tick();
        in_data = 16'hC002; in_sel = 2'b01; tick();
        in_data = 16'hC003; in_sel = 2'b10; tick();
        in_valid = 0;
        vec_cnt++; if ({vld1, vld2, vld3} !== 3'b111) begin miss_cnt++; $display("FAIL mid_full: got %b want 111", {vld1, vld2, vld3}); end
        #2;
        rst_n = 0;
        #1;
        vec_cnt++; if ({vld1, vld2, vld3} !== 3'b000) begin miss_cnt++; $display("FAIL mid_vld: got %b want 000", {vld1, vld2, vld3}); end
        vec_cnt++; if ({val1, val2, val3} !== 48'h0) begin miss_cnt++; $display("FAIL mid_val: got %h want 0", {val1, val2, val3}); end
        vec_cnt++; if (drop_cnt !== 8'h00 || sel_err !== 1'b0) begin miss_cnt++; $display("FAIL mid_cnt: got %h/%b want 00/0", drop_cnt, sel_err); end
        rdy1 = 1;
        in_valid = 1; in_data = 16'h9999; in_sel = 2'b00;
        tick();
        vec_cnt++; if (vld1 !== 1'b0) begin miss_cnt++; $display("FAIL mid_inflight: got %b want 0", vld1); end
        rst_n = 1;
        q1.delete(); q2.delete(); q3.delete();
        q1.push_back(16'h9999);
        tick();
        in_valid = 0;
        #1;
        exp_w = q1.pop_front();
        vec_cnt++; if (vld1 !== 1'b1 || val1 !== exp_w) begin miss_cnt++; $display("FAIL mid_first_xfer: got %b/%h want 1/%h", vld1, val1, exp_w); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_independent();
        test_drops();
        test_stream();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
